// File: rtl/superchip_ps2_rx.sv
// PS/2 keyboard receiver: synchronizes ps2_clk/ps2_data, deframes 11-bit frames and folds F0/E0 prefixes into flags.
// code_valid and frame_error are registered one-cycle strobes one clk after the stop-bit edge; there is no backpressure.
module superchip_ps2_rx #(
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic       clk,
    input  logic       res,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       key_released,
    output logic       key_extended,
    output logic       frame_error,
    output logic       busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             clk_s1_q, clk_s2_q, clk_prev_q;
    logic             dat_s1_q, dat_s2_q;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rel_pend_q, rel_pend_d;
    logic             ext_pend_q, ext_pend_d;
    logic [7:0]       scan_code_q, scan_code_d;
    logic             code_valid_q, code_valid_d;
    logic             key_released_q, key_released_d;
    logic             key_extended_q, key_extended_d;
    logic             frame_error_q, frame_error_d;
    logic             fall;

    assign fall = clk_prev_q & ~clk_s2_q;

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        parity_d       = parity_q;
        tmo_cnt_d      = tmo_cnt_q;
        rel_pend_d     = rel_pend_q;
        ext_pend_d     = ext_pend_q;
        scan_code_d    = scan_code_q;
        key_released_d = key_released_q;
        key_extended_d = key_extended_q;
        code_valid_d   = 1'b0;
        frame_error_d  = 1'b0;

        if (fall || state_q == IDLE) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end

        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = dat_s2_q;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (dat_s2_q && (^shift_q ^ parity_q)) begin
                        if (shift_q == 8'hF0) begin
                            rel_pend_d = 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_pend_d = 1'b1;
                        end else begin
                            scan_code_d    = shift_q;
                            key_released_d = rel_pend_q;
                            key_extended_d = ext_pend_q;
                            code_valid_d   = 1'b1;
                            rel_pend_d     = 1'b0;
                            ext_pend_d     = 1'b0;
                        end
                    end else begin
                        frame_error_d = 1'b1;
                        rel_pend_d    = 1'b0;
                        ext_pend_d    = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
            // A stalled keyboard clock abandons the frame and any prefix seen so far
            state_d       = IDLE;
            frame_error_d = 1'b1;
            rel_pend_d    = 1'b0;
            ext_pend_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q        <= IDLE;
            clk_s1_q       <= 1'b1;
            clk_s2_q       <= 1'b1;
            clk_prev_q     <= 1'b1;
            dat_s1_q       <= 1'b1;
            dat_s2_q       <= 1'b1;
            bit_cnt_q      <= 3'd0;
            shift_q        <= 8'h00;
            parity_q       <= 1'b0;
            tmo_cnt_q      <= '0;
            rel_pend_q     <= 1'b0;
            ext_pend_q     <= 1'b0;
            scan_code_q    <= 8'h00;
            code_valid_q   <= 1'b0;
            key_released_q <= 1'b0;
            key_extended_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            clk_s1_q       <= ps2_clk;
            clk_s2_q       <= clk_s1_q;
            clk_prev_q     <= clk_s2_q;
            dat_s1_q       <= ps2_data;
            dat_s2_q       <= dat_s1_q;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            parity_q       <= parity_d;
            tmo_cnt_q      <= tmo_cnt_d;
            rel_pend_q     <= rel_pend_d;
            ext_pend_q     <= ext_pend_d;
            scan_code_q    <= scan_code_d;
            code_valid_q   <= code_valid_d;
            key_released_q <= key_released_d;
            key_extended_q <= key_extended_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign scan_code    = scan_code_q;
    assign code_valid   = code_valid_q;
    assign key_released = key_released_q;
    assign key_extended = key_extended_q;
    assign frame_error  = frame_error_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_superchip_ps2_rx.sv
// Directed bench for superchip_ps2_rx: frame table plus latency, timeout and reset sequences.
module tb_superchip_ps2_rx;

    localparam int HALF = 8;
    localparam int TMO  = 4095;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       code_valid, key_released, key_extended, frame_error, busy;

    int checks = 0;
    int errors = 0;
    int cv_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    superchip_ps2_rx #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .res          (res),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .scan_code    (scan_code),
        .code_valid   (code_valid),
        .key_released (key_released),
        .key_extended (key_extended),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!res) begin
            if (code_valid) cv_cnt <= cv_cnt + 1;
            if (frame_error) err_cnt <= err_cnt + 1;
            if (code_valid && frame_error) both_cnt <= both_cnt + 1;
        end
    end

    typedef struct {
        logic [7:0] dat;
        logic       bad_par;
        logic       bad_stop;
        int         exp_cv;
        int         exp_err;
        logic [7:0] exp_code;
        logic       exp_rel;
        logic       exp_ext;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [10:0] bits);
        send_bits(bits, 11);
        ps2_data = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        int cv0, err0;
        vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
        vecs[1]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[2]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b1, 1'b0};
        vecs[3]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
        vecs[4]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[5]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[6]  = '{8'h75, 1'b0, 1'b0, 1, 0, 8'h75, 1'b1, 1'b1};
        vecs[7]  = '{8'h1C, 1'b1, 1'b0, 0, 1, 8'h75, 1'b1, 1'b1};
        vecs[8]  = '{8'h1C, 1'b0, 1'b1, 0, 1, 8'h75, 1'b1, 1'b1};
        vecs[9]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
        vecs[10] = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[11] = '{8'h1C, 1'b1, 1'b0, 0, 1, 8'h1C, 1'b0, 1'b0};
        vecs[12] = '{8'h2A, 1'b0, 1'b0, 1, 0, 8'h2A, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_scan", scan_code, 8'h00);
        chk("rst_cv", code_valid, 1'b0);
        chk("rst_rel", key_released, 1'b0);
        chk("rst_ext", key_extended, 1'b0);
        chk("rst_err", frame_error, 1'b0);
        chk("rst_busy", busy, 1'b0);
        res = 1'b0;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 13; v++) begin
            cv0  = cv_cnt;
            err0 = err_cnt;
            send_frame(mk_frame(vecs[v].dat, vecs[v].bad_par, vecs[v].bad_stop));
            chk($sformatf("v%0d_cv_pulses", v), cv_cnt - cv0, vecs[v].exp_cv);
            chk($sformatf("v%0d_err_pulses", v), err_cnt - err0, vecs[v].exp_err);
            chk($sformatf("v%0d_scan", v), scan_code, vecs[v].exp_code);
            chk($sformatf("v%0d_rel", v), key_released, vecs[v].exp_rel);
            chk($sformatf("v%0d_ext", v), key_extended, vecs[v].exp_ext);
            chk($sformatf("v%0d_busy", v), busy, 1'b0);
        end

        // Exact one-cycle latency from the synchronized stop edge
        send_bits(mk_frame(8'h5A, 1'b0, 1'b0), 10);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("lat_cv_early", code_valid, 1'b0);
        @(negedge clk);
        chk("lat_cv_on", code_valid, 1'b1);
        chk("lat_scan", scan_code, 8'h5A);
        @(negedge clk);
        chk("lat_cv_off", code_valid, 1'b0);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (16) @(negedge clk);

        // Timeout after 4 data bits
        cv0  = cv_cnt;
        err0 = err_cnt;
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 5);
        ps2_data = 1'b1;
        repeat (3900) @(negedge clk);
        chk("tmo_busy_before", busy, 1'b1);
        chk("tmo_err_before", err_cnt - err0, 0);
        repeat (400) @(negedge clk);
        chk("tmo_err_pulses", err_cnt - err0, 1);
        chk("tmo_busy_after", busy, 1'b0);
        chk("tmo_cv_pulses", cv_cnt - cv0, 0);
        send_frame(mk_frame(8'h1C, 1'b0, 1'b0));
        chk("tmo_recover_cv", cv_cnt - cv0, 1);
        chk("tmo_recover_scan", scan_code, 8'h1C);

        // Reset mid-frame after an F0 prefix
        send_frame(mk_frame(8'hF0, 1'b0, 1'b0));
        send_bits(mk_frame(8'h33, 1'b0, 1'b0), 5);
        chk("mid_busy", busy, 1'b1);
        cv0  = cv_cnt;
        err0 = err_cnt;
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_scan", scan_code, 8'h00);
        chk("mid_rst_rel", key_released, 1'b0);
        res = 1'b0;
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_rel_cv", cv_cnt - cv0, 0);
        chk("mid_rel_err", err_cnt - err0, 0);
        send_frame(mk_frame(8'h1C, 1'b0, 1'b0));
        chk("mid_after_cv", cv_cnt - cv0, 1);
        chk("mid_after_scan", scan_code, 8'h1C);
        chk("mid_after_rel", key_released, 1'b0);

        chk("cv_err_overlap", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/superchip_ps2_rx.md
SUPERCHIP_PS2_RX -- requirements
Module: superchip_ps2_rx

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 4095, number of clk cycles without a ps2_clk falling edge that aborts a frame in progress.
REQ-002 Port: clk  input  1  system clock; the block is synchronous to clk only.
REQ-003 Port: res  input  1  reset, asynchronous, active-high.
REQ-004 Port: ps2_clk  input  1  PS/2 clock from the keyboard source; asynchronous to clk.
REQ-005 Port: ps2_data  input  1  PS/2 data from the keyboard source; asynchronous to clk.
REQ-006 Port: scan_code  output  8  last accepted non-prefix scan code byte.
REQ-007 Port: code_valid  output  1  one-cycle strobe; scan_code, key_released and key_extended are valid in this cycle.
REQ-008 Port: key_released  output  1  an F0 prefix preceded the current code.
REQ-009 Port: key_extended  output  1  an E0 prefix preceded the current code.
REQ-010 Port: frame_error  output  1  one-cycle strobe for a parity, stop-bit or timeout failure.
REQ-011 Port: busy  output  1  high while a frame is being received (state not IDLE).

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; both flops reset to 1.
REQ-013 A falling edge SHALL be detected when the synchronized ps2_clk was 1 in the previous cycle and is 0 in the current cycle; synchronized ps2_data is sampled in that same cycle.
REQ-014 Frame format: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1.
REQ-015 States: IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: a falling edge with data=0 SHALL go to DATA with the bit counter cleared; a falling edge with data=1 SHALL be ignored.
REQ-017 DATA: each falling edge SHALL shift the sample into bit 7 of the shift register (right shift); after the 8th bit, go to PARITY.
REQ-018 PARITY: a falling edge SHALL store the parity bit and go to STOP.
REQ-019 STOP: a falling edge SHALL return to IDLE; the frame is accepted only if stop=1 and XOR(data byte, parity)=1; otherwise frame_error SHALL pulse.
REQ-020 An accepted byte 0xF0 SHALL set the pending-release flag; 0xE0 SHALL set the pending-extended flag; neither asserts code_valid.
REQ-021 Any other accepted byte SHALL load scan_code, copy the pending flags to key_released and key_extended, and pulse code_valid, all in the cycle after the stop-bit edge cycle.
REQ-022 Pending flags SHALL clear when code_valid pulses and on any frame_error.
REQ-023 scan_code, key_released and key_extended SHALL hold their values until the next code_valid.
REQ-024 Timeout counter: clears on every falling edge and in IDLE, and increments each cycle otherwise, saturating at TIMEOUT_CYCLES.
REQ-025 When the counter reaches TIMEOUT_CYCLES outside IDLE, the block SHALL return to IDLE and pulse frame_error once.
REQ-026 If a falling edge and a timeout occur in the same cycle, the edge SHALL take priority and no timeout occurs.
REQ-027 frame_error and code_valid SHALL never be high in the same cycle.
REQ-028 Total latency from the synchronized stop-bit falling edge to code_valid SHALL be exactly 1 clk cycle.

Reset
REQ-029 While res=1: state IDLE, counters 0, pending flags 0, scan_code 0x00, code_valid 0, key_released 0, key_extended 0, frame_error 0, busy 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; no strobe is produced on release.

Verification
REQ-031 Send frame 0x1C (parity 0, stop 1) -> one code_valid pulse, scan_code=0x1C, key_released=0, key_extended=0.
REQ-032 Send F0 then 1C -> exactly one code_valid, scan_code=0x1C, key_released=1; then send 1C -> key_released=0.
REQ-033 Send E0, F0, 75 -> one code_valid, scan_code=0x75, key_extended=1, key_released=1.
REQ-034 Send 0x1C with parity 1, or with stop bit 0 -> frame_error pulses once, no code_valid, scan_code unchanged; a following good 0x1C frame is accepted.
REQ-035 Stop ps2_clk after 4 data bits for more than TIMEOUT_CYCLES -> frame_error pulses once, busy=0; a subsequent full 0x1C frame is accepted.
REQ-036 Assert res in the middle of DATA after an F0 prefix, then release res and send 1C -> key_released=0, scan_code=0x1C.
